// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: N-player buzz-in front end.
// Sync, debounce, first-press latch, all-pressed and hold-to-start.
module buzzer_arbiter #(
    parameter int NUM_PLAYERS   = 4,
    parameter int SW_WIDTH      = 8,
    parameter int DB_CYCLES     = 100000,
    parameter int HOLD_CYCLES   = 250000000,
    parameter int PRIORITY_MODE = 0,
    localparam int ID_W         = $clog2(NUM_PLAYERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PLAYERS-1:0]        btn_raw,
    input  logic [NUM_PLAYERS*SW_WIDTH-1:0] sw_raw,
    input  logic                          arm,
    input  logic                          clear,
    output logic                          armed,
    output logic                          winner_valid,
    output logic [ID_W-1:0]               winner_id,
    output logic [SW_WIDTH-1:0]           winner_sw,
    output logic                          all_pressed,
    output logic                          game_started,
    output logic [ID_W-1:0]               start_id
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int SW_TOT = NUM_PLAYERS * SW_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NUM_PLAYERS-1:0]   btn_s1, btn_s2;
    logic [SW_TOT-1:0]        sw_s1, sw_s2;
    logic [NUM_PLAYERS-1:0]   db, db_q, rise;
    logic [DB_W-1:0]          db_cnt [NUM_PLAYERS];
    logic [HD_W-1:0]          hold_cnt [NUM_PLAYERS];
    logic [SW_WIDTH-1:0]      sw_arr [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]   hit;
    logic [ID_W-1:0]          hit_id;
    logic [ID_W-1:0]          ptr, pick, sh;
    logic [2*NUM_PLAYERS-1:0] rot;
    logic                     found;
    logic                     any_rise, all_db, latch;

    // Two-flop synchronisers for buttons and switches
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: level follows sync2 after DB_CYCLES consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) db_cnt[i] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (btn_s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db[i]     <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise     = db & ~db_q;
    assign any_rise = |rise;
    assign all_db   = &db;

    // Per-player view of the synchronised switch bank
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            sw_arr[i] = sw_s2[i*SW_WIDTH +: SW_WIDTH];
        end
    end

    // Winner pick: rotate rises so the scan starts at ptr (or 0 in fixed mode)
    always_comb begin
        sh    = (PRIORITY_MODE != 0) ? ptr : '0;
        rot   = {rise, rise} >> sh;
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pick  = ID_W'((int'(sh) + j) % NUM_PLAYERS);
            end
        end
    end

    assign latch = (state == ARMED) && !clear && any_rise && !all_db;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; clear wins over arm and over a rise
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!clear && arm) state_nxt = ARMED;
            end
            ARMED: begin
                if (clear)      state_nxt = IDLE;
                else if (latch) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (clear) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        armed        = (state == ARMED);
        winner_valid = (state == LOCKED);
    end

    // Winner capture and rotate pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            winner_id <= '0;
            winner_sw <= '0;
            ptr       <= '0;
        end else if (clear) begin
            winner_id <= '0;
            winner_sw <= '0;
        end else if (latch) begin
            winner_id <= pick;
            winner_sw <= sw_arr[pick];
            if (PRIORITY_MODE != 0) begin
                ptr <= ID_W'((int'(pick) + 1) % NUM_PLAYERS);
            end
        end
    end

    // All-pressed pulse: a rise that completes the full set
    always_ff @(posedge clk) begin
        if (rst) all_pressed <= 1'b0;
        else     all_pressed <= any_rise & all_db;
    end

    // Players whose hold counter reaches the limit on this edge, lowest wins
    always_comb begin
        hit_id = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            hit[i] = db[i] && (hold_cnt[i] == HD_W'(HOLD_CYCLES - 1));
        end
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (hit[i]) hit_id = ID_W'(i);
        end
    end

    // Hold counters and sticky game_started
    always_ff @(posedge clk) begin
        if (rst) begin
            game_started <= 1'b0;
            start_id     <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (!db[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HD_W'(HOLD_CYCLES)) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
            if (!game_started && |hit) begin
                game_started <= 1'b1;
                start_id     <= hit_id;
            end
        end
    end

endmodule
